// File: rtl/cpu_controller.sv
// cpu_controller: Moore FSM sequencing fetch, decode, execute and memory phases of a simple CPU datapath.
// Ports: clk/reset (sync, active-high); opcode/op/cond and status_z/n/v pick the decode path; mem_ready ends
// memory waits. Outputs nsel/vsel/load*/write/asel/bsel/pc_sel/msel/mread/mwrite/loadir/halted/fault are
// registered per state. state exposes the current encoding for debug.
module cpu_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic [2:0] cond,
  input  logic       status_z,
  input  logic       status_n,
  input  logic       status_v,
  input  logic       mem_ready,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic       loadc,
  output logic       loads,
  output logic       loadpc,
  output logic       pc_sel,
  output logic       msel,
  output logic       mread,
  output logic       mwrite,
  output logic       loadir,
  output logic       halted,
  output logic       fault,
  output logic [4:0] state
);
  typedef enum logic [4:0] {
    RESET, FETCH, LOADIR, INCPC, DECODE, WR_IMM, LD_B, LD_A, EXEC_A, EXEC_B,
    CMP, WB, ADDR, LD_RD, MEM_RD, WB_MEM, MEM_WR, BRANCH, HALT, FAULT
  } state_t;
  typedef struct packed {
    logic [1:0] nsel, vsel;
    logic loada, loadb, write, asel, bsel, loadc, loads, loadpc, pc_sel, msel, mread, mwrite, loadir, halted, fault;
  } ctl_t;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT > 0 ? MEM_TIMEOUT - 1 : 0);
  state_t state_q, state_d, dec_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  ctl_t out_q;
  logic [4:0] oc_op;
  logic nv, taken, bad_cond, tmo;
  function automatic ctl_t ctl_of(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  c.mread = 1'b1;
      LOADIR: c.loadir = 1'b1;
      INCPC:  c.loadpc = 1'b1;
      WR_IMM: begin c.vsel = 2'b01; c.write = 1'b1; end
      LD_B:   begin c.nsel = 2'b10; c.loadb = 1'b1; end
      LD_A:   c.loada = 1'b1;
      EXEC_A: c.loadc = 1'b1;
      EXEC_B: begin c.asel = 1'b1; c.loadc = 1'b1; end
      CMP:    c.loads = 1'b1;
      WB:     begin c.nsel = 2'b01; c.vsel = 2'b11; c.write = 1'b1; end
      ADDR:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
      LD_RD:  begin c.nsel = 2'b01; c.loadb = 1'b1; end
      MEM_RD: begin c.msel = 1'b1; c.mread = 1'b1; end
      WB_MEM: begin c.nsel = 2'b01; c.write = 1'b1; end
      MEM_WR: begin c.msel = 1'b1; c.mwrite = 1'b1; end
      BRANCH: begin c.loadpc = 1'b1; c.pc_sel = 1'b1; end
      HALT:   c.halted = 1'b1;
      FAULT:  c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
  always_comb begin
    oc_op = {opcode, op};
    nv = status_n ^ status_v;
    bad_cond = cond > 3'd4;
    taken = cond == 3'd0 ? 1'b1 : cond == 3'd1 ? status_z : cond == 3'd2 ? !status_z :
            cond == 3'd3 ? nv : nv | status_z;
    // mem_ready in the last allowed wait cycle still wins over the timeout
    tmo = (MEM_TIMEOUT != 0) && !mem_ready && cnt_q == TMO_LAST;
    dec_d = opcode == 3'b111 ? HALT :
            oc_op == 5'b110_10 ? WR_IMM :
            (oc_op == 5'b110_00 || opcode == 3'b101) ? LD_B :
            (oc_op == 5'b011_00 || oc_op == 5'b100_00) ? LD_A :
            (oc_op != 5'b001_00 || bad_cond) ? FAULT :
            taken ? BRANCH : FETCH;
    state_d = FAULT;
    case (state_q)
      RESET:                          state_d = FETCH;
      FETCH:                          state_d = mem_ready ? LOADIR : tmo ? FAULT : FETCH;
      LOADIR:                         state_d = INCPC;
      INCPC:                          state_d = DECODE;
      DECODE:                         state_d = dec_d;
      WR_IMM, CMP, WB, WB_MEM, BRANCH: state_d = FETCH;
      LD_B:                           state_d = (oc_op == 5'b110_00 || oc_op == 5'b101_11) ? EXEC_B : LD_A;
      LD_A:                           state_d = (opcode == 3'b011 || opcode == 3'b100) ? ADDR : op == 2'b01 ? CMP : EXEC_A;
      EXEC_A, EXEC_B:                 state_d = WB;
      ADDR:                           state_d = opcode == 3'b011 ? MEM_RD : LD_RD;
      LD_RD:                          state_d = MEM_WR;
      MEM_RD:                         state_d = mem_ready ? WB_MEM : tmo ? FAULT : MEM_RD;
      MEM_WR:                         state_d = mem_ready ? FETCH : tmo ? FAULT : MEM_WR;
      HALT:                           state_d = HALT;
      default:                        state_d = FAULT;
    endcase
    // only a wait state staying put counts; any entry starts from zero
    cnt_d = (state_d == state_q && (state_q == FETCH || state_q == MEM_RD || state_q == MEM_WR)) ?
            cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      out_q <= ctl_of(state_d);
    end
  end
  assign {nsel, vsel, loada, loadb, write, asel, bsel, loadc, loads, loadpc, pc_sel, msel, mread, mwrite,
          loadir, halted, fault} = out_q;
  assign state = state_q;
endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: directed scoreboard bench; driver queues expected state per cycle, monitor checks state and controls.
module tb_cpu_controller;
  typedef enum logic [4:0] {
    RESET, FETCH, LOADIR, INCPC, DECODE, WR_IMM, LD_B, LD_A, EXEC_A, EXEC_B,
    CMP, WB, ADDR, LD_RD, MEM_RD, WB_MEM, MEM_WR, BRANCH, HALT, FAULT
  } st_t;
  typedef struct packed {
    logic [1:0] nsel, vsel;
    logic loada, loadb, write, asel, bsel, loadc, loads, loadpc, pc_sel, msel, mread, mwrite, loadir, halted, fault;
  } ctl_t;
  logic clk = 1'b0, reset = 1'b1;
  logic [2:0] opcode = '0, cond = '0;
  logic [1:0] op = '0;
  logic status_z = 1'b0, status_n = 1'b0, status_v = 1'b0, mem_ready = 1'b1;
  logic [1:0] nsel, vsel;
  logic loada, loadb, write, asel, bsel, loadc, loads, loadpc, pc_sel, msel, mread, mwrite, loadir, halted, fault;
  logic [4:0] state;
  int errors = 0, checks = 0;
  st_t q[$];
  st_t e;
  ctl_t act;
  assign act = {nsel, vsel, loada, loadb, write, asel, bsel, loadc, loads, loadpc, pc_sel, msel, mread, mwrite,
                loadir, halted, fault};
  cpu_controller #(.MEM_TIMEOUT(4), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .cond(cond),
    .status_z(status_z), .status_n(status_n), .status_v(status_v), .mem_ready(mem_ready),
    .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb), .write(write), .asel(asel), .bsel(bsel),
    .loadc(loadc), .loads(loads), .loadpc(loadpc), .pc_sel(pc_sel), .msel(msel), .mread(mread),
    .mwrite(mwrite), .loadir(loadir), .halted(halted), .fault(fault), .state(state)
  );
  always #5 clk = ~clk;
  function automatic ctl_t spec_out(st_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH:  c.mread = 1'b1;
      LOADIR: c.loadir = 1'b1;
      INCPC:  c.loadpc = 1'b1;
      WR_IMM: begin c.nsel = 2'b00; c.vsel = 2'b01; c.write = 1'b1; end
      LD_B:   begin c.nsel = 2'b10; c.loadb = 1'b1; end
      LD_A:   begin c.nsel = 2'b00; c.loada = 1'b1; end
      EXEC_A: c.loadc = 1'b1;
      EXEC_B: begin c.asel = 1'b1; c.loadc = 1'b1; end
      CMP:    c.loads = 1'b1;
      WB:     begin c.nsel = 2'b01; c.vsel = 2'b11; c.write = 1'b1; end
      ADDR:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
      LD_RD:  begin c.nsel = 2'b01; c.loadb = 1'b1; end
      MEM_RD: begin c.msel = 1'b1; c.mread = 1'b1; end
      WB_MEM: begin c.nsel = 2'b01; c.vsel = 2'b00; c.write = 1'b1; end
      MEM_WR: begin c.msel = 1'b1; c.mwrite = 1'b1; end
      BRANCH: begin c.loadpc = 1'b1; c.pc_sel = 1'b1; end
      HALT:   c.halted = 1'b1;
      FAULT:  c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (state !== e || act !== spec_out(e)) begin
        errors++;
        $display("FAIL cycle_check #%0d: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                 checks, state, act, e, spec_out(e));
      end
    end
  end
  task automatic step(input st_t s);
    q.push_back(s);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic instr(input logic [2:0] oc, input logic [1:0] o, input logic [2:0] c);
    opcode = oc;
    op = o;
    cond = c;
    step(LOADIR);
    step(INCPC);
    step(DECODE);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(RESET);
    reset = 1'b0;
    mem_ready = 1'b1;
    step(FETCH);
  endtask
  task automatic scramble();
    {opcode, op, cond, status_z, status_n, status_v, mem_ready} = 12'($urandom);
  endtask
  initial begin
    @(negedge clk);
    step(RESET);
    step(RESET);
    reset = 1'b0;
    step(FETCH);
    instr(3'b110, 2'b10, 3'd0); step(WR_IMM); step(FETCH);
    instr(3'b101, 2'b00, 3'd0); step(LD_B); step(LD_A); step(EXEC_A); step(WB); step(FETCH);
    instr(3'b110, 2'b00, 3'd0); step(LD_B); step(EXEC_B); step(WB); step(FETCH);
    instr(3'b101, 2'b11, 3'd0); step(LD_B); step(EXEC_B); step(WB); step(FETCH);
    instr(3'b101, 2'b01, 3'd0); step(LD_B); step(LD_A); step(CMP); step(FETCH);
    status_z = 1'b1; instr(3'b001, 2'b00, 3'd1); step(BRANCH); step(FETCH);
    status_z = 1'b0; instr(3'b001, 2'b00, 3'd1); step(FETCH);
    instr(3'b001, 2'b00, 3'd2); step(BRANCH); step(FETCH);
    status_n = 1'b1; instr(3'b001, 2'b00, 3'd3); step(BRANCH); step(FETCH);
    status_n = 1'b0; instr(3'b001, 2'b00, 3'd4); step(FETCH);
    status_v = 1'b1; instr(3'b001, 2'b00, 3'd4); step(BRANCH); step(FETCH);
    status_v = 1'b0; instr(3'b001, 2'b00, 3'd0); step(BRANCH); step(FETCH);
    instr(3'b011, 2'b00, 3'd0); step(LD_A); step(ADDR); step(MEM_RD);
    mem_ready = 1'b0; repeat (3) step(MEM_RD);
    mem_ready = 1'b1; step(WB_MEM); step(FETCH);
    instr(3'b100, 2'b00, 3'd0); step(LD_A); step(ADDR); step(LD_RD); step(MEM_WR);
    mem_ready = 1'b0; repeat (3) step(MEM_WR);
    mem_ready = 1'b1; step(FETCH);
    mem_ready = 1'b0; repeat (3) step(FETCH);
    mem_ready = 1'b1;
    instr(3'b010, 2'b00, 3'd0); step(FAULT);
    repeat (3) begin scramble(); step(FAULT); end
    do_reset();
    instr(3'b001, 2'b00, 3'd5); step(FAULT);
    do_reset();
    instr(3'b111, 2'b00, 3'd0); step(HALT);
    repeat (12) begin scramble(); step(HALT); end
    do_reset();
    instr(3'b100, 2'b00, 3'd0); step(LD_A); step(ADDR); step(LD_RD); step(MEM_WR);
    mem_ready = 1'b0; step(MEM_WR);
    reset = 1'b1; step(RESET);
    reset = 1'b0; step(FETCH);
    repeat (3) step(FETCH);
    step(FAULT);
    repeat (20) begin scramble(); reset = 1'b0; step(FAULT); end
    reset = 1'b1; step(RESET); step(RESET);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
